// File: rtl/d_flip_flop_pkg.sv
// Shared types for the master-slave D flip-flop. These cover the decode of the
// asynchronous controls and the debug view of the internal latch state.
package d_flip_flop_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN    = 2'd0,
        CTRL_RESET  = 2'd1,
        CTRL_PRESET = 2'd2
    } ctrl_mode_e;

    typedef struct packed {
        ctrl_mode_e mode;
        logic       master_q;
        logic       master_q_bar;
    } dff_debug_t;

    // Reset beats preset when both are asserted, so Q and Qbar never agree.
    function automatic ctrl_mode_e decode_ctrl(input logic r, input logic n_p);
        if (r) begin
            return CTRL_RESET;
        end
        if (!n_p) begin
            return CTRL_PRESET;
        end
        return CTRL_RUN;
    endfunction

endpackage

// File: rtl/d_flip_flop_if.sv
// Data, preset and output bundle of the flip-flop. Clock and reset stay as
// plain ports. The master drives nP and D, and the slave drives Q, Qbar and debug.
interface d_flip_flop_if;
    import d_flip_flop_pkg::*;

    logic       nP;
    logic       D;
    logic       Q;
    logic       Qbar;
    dff_debug_t debug;

    modport master (output nP, D, input Q, Qbar, debug);
    modport slave  (input nP, D, output Q, Qbar, debug);

endinterface

// File: rtl/d_flip_flop_d_latch.sv
// Level-sensitive D latch with asynchronous reset (active-high) and preset
// (active-low). Reset has priority over preset, and Qbar is derived from the same state bit.
module d_latch
    import d_flip_flop_pkg::*;
(
    input  logic D,
    input  logic enable,
    input  logic R,
    input  logic nP,
    output logic Q,
    output logic Qbar
);

    ctrl_mode_e mode;
    logic       state;

    assign mode = decode_ctrl(R, nP);

    always_latch begin
        if (mode == CTRL_RESET) begin
            state <= 1'b0;
        end else if (mode == CTRL_PRESET) begin
            state <= 1'b1;
        end else if (enable) begin
            state <= D;
        end
    end

    assign Q    = state;
    assign Qbar = ~state;

endmodule

// File: rtl/d_flip_flop.sv
// Rising-edge D flip-flop built from two latches. The master is open while
// C is low, and the slave is open while C is high.
module d_flip_flop
    import d_flip_flop_pkg::*;
(
    input  logic          C,
    input  logic          R,
    d_flip_flop_if.slave  bus
);

    logic c_n;
    logic master_q;
    logic master_q_bar;

    assign c_n = ~C;

    d_latch u_master (
        .D      (bus.D),
        .enable (c_n),
        .R      (R),
        .nP     (bus.nP),
        .Q      (master_q),
        .Qbar   (master_q_bar)
    );

    // Releasing R or nP while C is high leaves the master closed, so no capture happens until the next rise.
    d_latch u_slave (
        .D      (master_q),
        .enable (C),
        .R      (R),
        .nP     (bus.nP),
        .Q      (bus.Q),
        .Qbar   (bus.Qbar)
    );

    assign bus.debug = '{mode: decode_ctrl(R, bus.nP),
                         master_q: master_q,
                         master_q_bar: master_q_bar};

endmodule

// File: tb/tb_d_flip_flop.sv
// Bench for d_flip_flop. It runs the directed sequences from the test plan and then
// a random walk over C, D, R and nP, checked against an event-level model.
module tb_d_flip_flop;
    import d_flip_flop_pkg::*;

    logic C;
    logic R;
    d_flip_flop_if bus ();

    d_flip_flop dut (
        .C   (C),
        .R   (R),
        .bus (bus.slave)
    );

    int   checks = 0;
    int   errors = 0;
    logic model_q;
    logic prev_c;
    logic cur_c, cur_r, cur_np, cur_d;

    task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One input change, then settle. The model follows the behavioural rules:
    // reset first, then preset, else a 0->1 edge of C loads D.
    task automatic apply(input string tag);
        C      = cur_c;
        R      = cur_r;
        bus.nP = cur_np;
        bus.D  = cur_d;
        #2;
        if (cur_r) begin
            model_q = 1'b0;
        end else if (!cur_np) begin
            model_q = 1'b1;
        end else if (cur_c && !prev_c) begin
            model_q = cur_d;
        end
        prev_c = cur_c;
        check_val({tag, ".q"},    {3'b0, bus.Q},    {3'b0, model_q});
        check_val({tag, ".qbar"}, {3'b0, bus.Qbar}, {3'b0, ~model_q});
        check_val({tag, ".mode"}, {2'b0, bus.debug.mode},
                  cur_r ? {2'b0, CTRL_RESET} : (!cur_np ? {2'b0, CTRL_PRESET} : {2'b0, CTRL_RUN}));
    endtask

    task automatic set_c(input logic v, input string tag);
        #3;
        cur_c = v;
        apply(tag);
    endtask

    task automatic set_d(input logic v, input string tag);
        cur_d = v;
        apply(tag);
    endtask

    task automatic set_r(input logic v, input string tag);
        cur_r = v;
        apply(tag);
    endtask

    task automatic set_np(input logic v, input string tag);
        cur_np = v;
        apply(tag);
    endtask

    initial begin
        cur_c   = 1'b0;
        cur_r   = 1'b1;
        cur_np  = 1'b1;
        cur_d   = 1'b0;
        prev_c  = 1'b0;
        model_q = 1'b0;
        apply("reset_init");
        check_val("reset_init_lit", {3'b0, bus.Q}, 4'd0);

        // Clock edges with D=1 are ignored while reset is held.
        set_d(1'b1, "reset_d1");
        set_c(1'b1, "reset_rise1");
        set_c(1'b0, "reset_fall1");
        set_c(1'b1, "reset_rise2");
        check_val("reset_hold_lit", {3'b0, bus.Q}, 4'd0);
        set_c(1'b0, "reset_fall2");

        // Capture a one, then ignore D while C is high and on the falling edge.
        set_r(1'b0, "cap_release");
        set_c(1'b1, "cap_rise");
        check_val("cap_one_lit", {3'b0, bus.Q}, 4'd1);
        set_d(1'b0, "cap_d_high_phase");
        check_val("cap_hold_lit", {3'b0, bus.Q}, 4'd1);
        set_c(1'b0, "cap_fall");
        check_val("cap_fall_lit", {3'b0, bus.Q}, 4'd1);

        set_c(1'b1, "cap_zero_rise");
        check_val("cap_zero_lit", {3'b0, bus.Q}, 4'd0);

        // Asynchronous preset with C low, then release and hold until the next rise.
        set_c(1'b0, "pre_fall");
        set_np(1'b0, "pre_assert");
        check_val("pre_assert_lit", {3'b0, bus.Q}, 4'd1);
        set_np(1'b1, "pre_release");
        check_val("pre_release_lit", {3'b0, bus.Q}, 4'd1);
        set_c(1'b1, "pre_next_rise");
        check_val("pre_next_rise_lit", {3'b0, bus.Q}, 4'd0);

        // Reset wins over preset, and preset takes over once reset drops.
        set_r(1'b1, "both_r");
        set_np(1'b0, "both_np");
        check_val("both_lit", {3'b0, bus.Qbar}, 4'd1);
        set_r(1'b0, "both_r_drop");
        check_val("both_r_drop_lit", {3'b0, bus.Q}, 4'd1);
        set_np(1'b1, "both_np_drop");

        // Reset released during C high must not capture D.
        set_r(1'b1, "rel_r");
        set_c(1'b0, "rel_fall");
        set_c(1'b1, "rel_rise");
        set_d(1'b1, "rel_d1");
        set_r(1'b0, "rel_r_drop");
        check_val("rel_no_capture_lit", {3'b0, bus.Q}, 4'd0);
        set_c(1'b0, "rel_fall2");
        check_val("rel_fall2_lit", {3'b0, bus.Q}, 4'd0);
        set_c(1'b1, "rel_rise2");
        check_val("rel_rise2_lit", {3'b0, bus.Q}, 4'd1);

        // Random walk: change one input per step so D is never moving at an edge.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: set_c(~cur_c, "rnd_c");
                5, 6, 7:       set_d(1'($urandom_range(0, 1)), "rnd_d");
                8:             set_r($urandom_range(0, 3) == 0, "rnd_r");
                default:       set_np($urandom_range(0, 3) != 0, "rnd_np");
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
